logic_unit_pipe: RTL
====================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit: successor to the fixed 32-bit AND array in the ALU datapath.
- Adds selectable operation (AND/OR/XOR/NOR), a zero flag and a configurable number of registered stages.
- Adds valid/ready flow control on both sides, so the ALU issue logic and writeback can stall it independently.

Parameters:
- WIDTH, 32: operand and result width in bits; legal range 1..64.
- STAGES, 2: number of register stages between input and output; legal range 1..4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents a valid operation.
- in_ready  output  1  unit accepts an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  operation select: 0 AND, 1 OR, 2 XOR, 3 NOR.
- out_valid  output  1  result/zero valid.
- out_ready  input  1  downstream accepts result this cycle.
- result  output  WIDTH  bitwise result.
- zero  output  1  1 when result is all zeros.
- op_count  output  32  completed-operation counter (see Optional Feature).

Behaviour:
- Reset (async assert, sync-safe deassert by the surrounding design):
  - All stage valid bits clear; out_valid=0, result=0, zero=0, op_count=0.
  - in_ready=1 as soon as rst deasserts.
- Compute:
  - The operation is evaluated combinationally from a, b and op at the input.
  - Stage 0 captures result and zero on an input handshake (in_valid && in_ready).
  - Stages 1..STAGES-1 pass the captured values forward; the last stage drives the outputs.
- Latency:
  - Exactly STAGES cycles from input handshake to out_valid, when unstalled.
  - Throughput is 1 op/cycle with out_ready held at 1.
- Stage advance:
  - Stage k loads when it is empty or its contents leave this cycle.
  - Per stage: ready_k = !valid_k || ready_{k+1}; ready after the last stage = out_ready.
  - in_ready = ready_0. This is a combinational ready chain; no skid buffer.
- Stall:
  - While out_valid=1 and out_ready=0, result, zero and out_valid hold stable.
  - Bubbles ahead of the stall are compressed: an empty stage still loads.
- Simultaneous events: the same stage emptying and filling in one cycle loads the new data; no loss and no duplication.
- Order: strictly in-order; no reordering or dropping.
- Inputs a, b and op are ignored when in_valid=0.
- Reset mid-operation flushes all in-flight ops. No output is produced for them.
- WIDTH arithmetic: zero = ~|result over all WIDTH bits. NOR is the bitwise inverse of OR over WIDTH bits only.

Optional Feature:
- Macro: LOGIC_UNIT_PIPE_PERF_EN.
- Defined:
  - op_count increments by 1 on every output handshake (out_valid && out_ready).
  - It saturates at 32'hFFFF_FFFF and clears on rst.
- Undefined:
  - op_count is tied to 0 and no counter flops are synthesised.
  - All other behaviour is identical.

Test Plan:
- Reset then single op (WIDTH=32, STAGES=2):
  - Stimulus: a=0xF0F0_1234, b=0x0FF0_FFFF, op=0 (AND), one cycle of in_valid, out_ready=1.
  - Response: out_valid exactly 2 cycles later; result=0x00F0_1234, zero=0.
- Back-to-back stream:
  - Stimulus: ops OR, XOR, NOR with a=0xAAAA_AAAA, b=0x5555_5555 on consecutive cycles.
  - Response: results 0xFFFF_FFFF, 0xFFFF_FFFF, 0x0000_0000 (zero=1) on 3 consecutive cycles.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while in_valid=1 continuously.
  - Response: in_ready drops after STAGES ops are accepted; output holds the first result stable; after release, all accepted results appear in order with none lost.
- Reset mid-flight:
  - Stimulus: assert rst while 2 ops are in flight.
  - Response: out_valid=0 immediately (async); neither op appears after release.
- Parameter sweep:
  - Stimulus: WIDTH=8, STAGES=1 and WIDTH=64, STAGES=4 with random ops against a reference model.
  - Response: latency equals STAGES; results bit-exact.
- Perf counter (LOGIC_UNIT_PIPE_PERF_EN defined):
  - Stimulus: 10 output handshakes with 3 stall cycles interleaved.
  - Response: op_count=10. With the macro undefined, op_count stays 0.

Source files
------------

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe
// Brief    : Pipelined AND/OR/XOR/NOR unit with zero flag and valid/ready
//            flow control. Define LOGIC_UNIT_PIPE_PERF_EN for op_count.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [31:0]      op_count
);

   logic [WIDTH-1:0] w_res;
   logic             w_zero;
   logic [STAGES:0]  w_rdy;

   logic [STAGES-1:0] r_vld;
   logic [STAGES-1:0] r_zero;
   logic [WIDTH-1:0]  r_data [STAGES];

   always_comb begin
      w_res = a & b;
      case (op)
         2'd0:    w_res = a & b;
         2'd1:    w_res = a | b;
         2'd2:    w_res = a ^ b;
         default: w_res = ~(a | b);
      endcase
   end

   assign w_zero = ~|w_res;

   // Ready chain walks backwards from the output inside one process.
   always_comb begin
      w_rdy         = '0;
      w_rdy[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         w_rdy[k] = ~r_vld[k] | w_rdy[k+1];
      end
   end

   assign in_ready = w_rdy[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld  <= '0;
         r_zero <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_data[k] <= '0;
         end
      end else begin
         if (w_rdy[0]) begin
            r_vld[0] <= in_valid;
            if (in_valid) begin
               r_data[0] <= w_res;
               r_zero[0] <= w_zero;
            end
         end
         for (int k = 1; k < STAGES; k++) begin
            if (w_rdy[k]) begin
               r_vld[k]  <= r_vld[k-1];
               r_data[k] <= r_data[k-1];
               r_zero[k] <= r_zero[k-1];
            end
         end
      end
   end

   assign out_valid = r_vld[STAGES-1];
   assign result    = r_data[STAGES-1];
   assign zero      = r_zero[STAGES-1];

`ifdef LOGIC_UNIT_PIPE_PERF_EN
   logic [31:0] r_op_count;

   // Saturating count of output handshakes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op_count <= '0;
      end else if (out_valid && out_ready && (r_op_count != 32'hFFFF_FFFF)) begin
         r_op_count <= r_op_count + 32'd1;
      end
   end

   assign op_count = r_op_count;
`else
   assign op_count = '0;
`endif

endmodule
`default_nettype wire
